// File: rtl/pam4_pkg.sv
// Shared definitions for the PAM4 transmitter: state encoding, PRBS7
// constants, Gray-to-level mapping and output saturation helpers.
package pam4_pkg;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_SEND  = 2'd2
    } pam4_state_e;

    // PRBS7 polynomial x^7 + x^6 + 1: feedback taps are bits 6 and 5.
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    // Gray-coded symbol to signed level. Inner levels sit at +/-sep/2,
    // outer levels one separation further out.
    function automatic int gray_to_level(input logic [1:0] sym, input int sep);
        int l0;
        int l1;
        l0 = sep / 2;
        l1 = sep / 2 + sep;
        case (sym)
            2'b00:   gray_to_level = -l1;
            2'b01:   gray_to_level = -l0;
            2'b11:   gray_to_level =  l0;
            default: gray_to_level =  l1;
        endcase
    endfunction

    // Symmetric saturation to +/-(2^(res-1)-1) so the most negative code
    // is never produced.
    function automatic int saturate(input int val, input int res);
        int lim;
        lim = (1 << (res - 1)) - 1;
        if (val > lim) begin
            saturate = lim;
        end else if (val < -lim) begin
            saturate = -lim;
        end else begin
            saturate = val;
        end
    endfunction

endpackage

// File: rtl/pam4_tx_prbs7.sv
// PRBS7 training-symbol source. The LFSR advances two steps per enabled
// cycle; the first generated bit is the symbol MSB. The sequence carries on
// across bursts and only reset returns it to the seed.
module prbs7_gen
    import pam4_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    output logic [1:0] o_sym
);

    logic [6:0] r_lfsr;
    logic       w_b1;
    logic       w_b2;
    logic [6:0] w_step1;
    logic [6:0] w_step2;

    // Two chained LFSR steps computed from the current state.
    always_comb begin
        w_b1    = r_lfsr[PRBS7_TAP_A] ^ r_lfsr[PRBS7_TAP_B];
        w_step1 = {r_lfsr[5:0], w_b1};
        w_b2    = w_step1[PRBS7_TAP_A] ^ w_step1[PRBS7_TAP_B];
        w_step2 = {w_step1[5:0], w_b2};
    end

    assign o_sym = {w_b1, w_b2};

    // Advance by one symbol (two bits) whenever a training symbol is consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= PRBS7_SEED;
        end else if (i_en) begin
            r_lfsr <= w_step2;
        end
    end

endmodule

// File: rtl/pam4_tx.sv
// PAM4 transmitter with a two-tap ISI channel model (h = [1, 2^-H1_SHIFT]).
// Bytes are sent MSB-first as four Gray-coded symbols; training bursts send
// PRBS7 symbols and expose the ideal pre-ISI level alongside the output.
//
// Handshake: a byte is transferred on every rising edge where
// data_in_valid && data_in_ready. The source must hold data_in stable while
// valid is high and ready is low; ready never depends on valid.
module pam4_tx
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int H1_SHIFT          = 1,
    parameter int TRAIN_LENGTH      = 127
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [7:0]                          data_in,
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    input  logic                                train_start,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] train_data,
    output logic                                train_data_valid,
    output logic                                busy,
    output logic [1:0]                          dbg_state
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_TRAIN = S_TRAIN;
    localparam logic [1:0] ST_SEND  = S_SEND;

    localparam int RES1 = SIGNAL_RESOLUTION + 1;
    localparam int TCW  = (TRAIN_LENGTH > 1) ? $clog2(TRAIN_LENGTH) : 1;

    logic [1:0]                          r_state;
    logic [1:0]                          r_sym_cnt;
    logic [TCW-1:0]                      r_train_cnt;
    logic [7:0]                          r_byte;
    logic signed [SIGNAL_RESOLUTION-1:0] r_hist;
    logic signed [SIGNAL_RESOLUTION-1:0] r_signal;
    logic                                r_signal_valid;
    logic signed [SIGNAL_RESOLUTION-1:0] r_train_data;
    logic                                r_train_valid;

    logic                                w_accept;
    logic                                w_training;
    logic                                w_sym_valid;
    logic [1:0]                          w_prbs_sym;
    logic [1:0]                          w_send_sym;
    logic [1:0]                          w_sym;
    logic signed [SIGNAL_RESOLUTION-1:0] w_level;
    logic signed [SIGNAL_RESOLUTION-1:0] w_x;
    logic signed [RES1-1:0]              w_sum;
    logic signed [SIGNAL_RESOLUTION-1:0] w_sat;

    // Ready in IDLE (unless training is requested, which wins) and on the
    // last symbol of a byte so bytes can stream without gaps.
    assign data_in_ready = rstn &&
                           (((r_state == ST_IDLE) && !train_start) ||
                            ((r_state == ST_SEND) && (r_sym_cnt == 2'd3)));
    assign w_accept      = data_in_valid && data_in_ready;

    assign w_training  = (r_state == ST_TRAIN);
    assign w_sym_valid = (r_state == ST_TRAIN) || (r_state == ST_SEND);

    prbs7_gen u_prbs (
        .clk   (clk),
        .rstn  (rstn),
        .i_en  (w_training),
        .o_sym (w_prbs_sym)
    );

    // Pick the current byte symbol, MSB pair first.
    always_comb begin
        w_send_sym = 2'b00;
        case (r_sym_cnt)
            2'd0:    w_send_sym = r_byte[7:6];
            2'd1:    w_send_sym = r_byte[5:4];
            2'd2:    w_send_sym = r_byte[3:2];
            default: w_send_sym = r_byte[1:0];
        endcase
    end

    // Map the active symbol to a level and apply the post-cursor tap.
    always_comb begin
        w_sym   = w_training ? w_prbs_sym : w_send_sym;
        w_level = SIGNAL_RESOLUTION'(gray_to_level(w_sym, SYMBOL_SEPERATION));
        w_x     = w_sym_valid ? w_level : '0;
        w_sum   = RES1'(w_x) + (RES1'(r_hist) >>> H1_SHIFT);
        w_sat   = SIGNAL_RESOLUTION'(saturate(int'(w_sum), SIGNAL_RESOLUTION));
    end

    // FSM, symbol counters and byte holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_sym_cnt   <= 2'd0;
            r_train_cnt <= '0;
            r_byte      <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (train_start) begin
                        r_state     <= ST_TRAIN;
                        r_train_cnt <= '0;
                    end else if (w_accept) begin
                        r_state   <= ST_SEND;
                        r_byte    <= data_in;
                        r_sym_cnt <= 2'd0;
                    end
                end
                ST_TRAIN: begin
                    if (r_train_cnt == TCW'(TRAIN_LENGTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_train_cnt <= '0;
                    end else begin
                        r_train_cnt <= r_train_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (r_sym_cnt == 2'd3) begin
                        r_sym_cnt <= 2'd0;
                        if (w_accept) begin
                            r_byte <= data_in;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel history and registered outputs; idle cycles feed x = 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist         <= '0;
            r_signal       <= '0;
            r_signal_valid <= 1'b0;
            r_train_data   <= '0;
            r_train_valid  <= 1'b0;
        end else begin
            r_hist         <= w_x;
            r_signal       <= w_sat;
            r_signal_valid <= w_sym_valid;
            r_train_data   <= w_training ? w_level : '0;
            r_train_valid  <= w_training;
        end
    end

    assign signal_out       = r_signal;
    assign signal_out_valid = r_signal_valid;
    assign train_data       = r_train_data;
    assign train_data_valid = r_train_valid;
    assign busy             = (r_state != ST_IDLE);
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_pam4_tx.sv
// Directed bench for pam4_tx: default-separation instance plus a SEP=80
// instance for saturation, gap and mid-byte reset behaviour.
module tb_pam4_tx;

    logic              clk;
    logic              rstn;
    logic [7:0]        data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic              train_start;
    logic signed [7:0] signal_out;
    logic              signal_out_valid;
    logic signed [7:0] train_data;
    logic              train_data_valid;
    logic              busy;
    logic [1:0]        dbg_state;

    logic              d2_rstn;
    logic [7:0]        d2_data_in;
    logic              d2_data_in_valid;
    logic              d2_data_in_ready;
    logic              d2_train_start;
    logic signed [7:0] d2_signal_out;
    logic              d2_signal_out_valid;
    logic signed [7:0] d2_train_data;
    logic              d2_train_data_valid;
    logic              d2_busy;
    logic [1:0]        d2_dbg_state;

    int n_checks;
    int n_fails;

    pam4_tx u_dut (
        .clk              (clk),
        .rstn             (rstn),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .train_start      (train_start),
        .signal_out       (signal_out),
        .signal_out_valid (signal_out_valid),
        .train_data       (train_data),
        .train_data_valid (train_data_valid),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    pam4_tx #(.SYMBOL_SEPERATION(80)) u_dut80 (
        .clk              (clk),
        .rstn             (d2_rstn),
        .data_in          (d2_data_in),
        .data_in_valid    (d2_data_in_valid),
        .data_in_ready    (d2_data_in_ready),
        .train_start      (d2_train_start),
        .signal_out       (d2_signal_out),
        .signal_out_valid (d2_signal_out_valid),
        .train_data       (d2_train_data),
        .train_data_valid (d2_train_data_valid),
        .busy             (d2_busy),
        .dbg_state        (d2_dbg_state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_8d[4];
        int exp_ff00[8];
        int exp_tr_sig[5];
        int exp_tr_dat[5];
        int exp_aa55[8];
        int exp_reseed[4];
        int n_valid;
        int n_tvalid;
        int end_j;

        exp_8d     = '{84, -42, -14, -14};
        exp_ff00   = '{28, 42, 42, 42, -70, -126, -126, -126};
        exp_tr_sig = '{-84, -126, -126, 42, -42};
        exp_tr_dat = '{-84, -84, -84, 84, -84};
        exp_aa55   = '{120, 127, 127, 127, -40, -60, -60, -60};
        exp_reseed = '{-84, -84, -84, 84};

        n_checks = 0;
        n_fails  = 0;

        rstn             = 1'b0;
        data_in          = 8'h00;
        data_in_valid    = 1'b0;
        train_start      = 1'b0;
        d2_rstn          = 1'b0;
        d2_data_in       = 8'h00;
        d2_data_in_valid = 1'b0;
        d2_train_start   = 1'b0;

        // Reset state.
        tick();
        tick();
        check_eq("rst_ready", data_in_ready, 0);
        check_eq("rst_sig", signal_out, 0);
        check_eq("rst_valid", signal_out_valid, 0);
        check_eq("rst_tdata", train_data, 0);
        check_eq("rst_tvalid", train_data_valid, 0);
        check_eq("rst_busy", busy, 0);
        rstn    = 1'b1;
        d2_rstn = 1'b1;
        #1;
        check_eq("idle_ready", data_in_ready, 1);
        check_eq("idle_valid", signal_out_valid, 0);
        tick();
        check_eq("idle_sig", signal_out, 0);
        check_eq("idle_busy", busy, 0);

        // Single byte 8'h8D from IDLE.
        data_in       = 8'h8D;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check_eq("b8d_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("b8d_sig", signal_out, exp_8d[i]);
            check_eq("b8d_valid", signal_out_valid, 1);
            check_eq("b8d_tvalid", train_data_valid, 0);
        end
        check_eq("b8d_idle", busy, 0);
        tick();
        check_eq("b8d_after_valid", signal_out_valid, 0);

        // Back-to-back bytes 8'hFF, 8'h00.
        data_in       = 8'hFF;
        data_in_valid = 1'b1;
        tick();
        data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) check_eq("b2b_ready_last", data_in_ready, 1);
            if (i == 1) check_eq("b2b_ready_mid", data_in_ready, 0);
            tick();
            if (i == 3) data_in_valid = 1'b0;
            check_eq("b2b_sig", signal_out, exp_ff00[i]);
            check_eq("b2b_valid", signal_out_valid, 1);
        end
        tick();
        check_eq("b2b_after_valid", signal_out_valid, 0);
        check_eq("b2b_idle", busy, 0);

        // Training burst from the seed; a second request mid-burst is ignored.
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        n_valid  = 0;
        n_tvalid = 0;
        end_j    = 0;
        for (int j = 1; j <= 160; j++) begin
            train_start = (j == 51);
            tick();
            if (signal_out_valid) n_valid++;
            if (train_data_valid) n_tvalid++;
            if (!busy && end_j == 0) end_j = j;
            if (j <= 5) begin
                check_eq("train_sig", signal_out, exp_tr_sig[j-1]);
                check_eq("train_data", train_data, exp_tr_dat[j-1]);
            end
            if (j == 10) check_eq("train_ready", data_in_ready, 0);
        end
        train_start = 1'b0;
        check_eq("train_nvalid", n_valid, 127);
        check_eq("train_ntvalid", n_tvalid, 127);
        check_eq("train_end_cycle", end_j, 127);

        // Training and a byte requested together: training wins, byte waits.
        data_in       = 8'h8D;
        data_in_valid = 1'b1;
        train_start   = 1'b1;
        #1;
        check_eq("prio_ready", data_in_ready, 0);
        tick();
        train_start = 1'b0;
        n_tvalid = 0;
        for (int j = 1; j <= 133; j++) begin
            tick();
            if (train_data_valid) n_tvalid++;
            if (j == 1) check_eq("prio_tdata0", train_data, -84);
            if (j == 64) check_eq("prio_ready_mid", data_in_ready, 0);
            if (j == 127) begin
                check_eq("prio_end_busy", busy, 0);
                check_eq("prio_end_ready", data_in_ready, 1);
            end
            if (j == 128) begin
                data_in_valid = 1'b0;
                check_eq("prio_accept_busy", busy, 1);
            end
            if (j >= 129 && j <= 132) begin
                check_eq("prio_byte_sig", signal_out, exp_8d[j-129]);
                check_eq("prio_byte_tvalid", train_data_valid, 0);
            end
        end
        check_eq("prio_ntvalid", n_tvalid, 127);

        // Reset mid-burst reseeds the PRBS.
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        rstn = 1'b0;
        #1;
        check_eq("trst_sig", signal_out, 0);
        check_eq("trst_tdata", train_data, 0);
        check_eq("trst_tvalid", train_data_valid, 0);
        check_eq("trst_busy", busy, 0);
        tick();
        rstn = 1'b1;
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check_eq("reseed_tdata", train_data, exp_reseed[j]);
        end

        // SEP = 80: saturation, then a gap clears the ISI history.
        d2_data_in       = 8'hAA;
        d2_data_in_valid = 1'b1;
        tick();
        d2_data_in_valid = 1'b0;
        d2_data_in       = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("sep80_aa_sig", d2_signal_out, exp_aa55[i]);
        end
        tick();
        check_eq("sep80_gap_valid", d2_signal_out_valid, 0);
        tick();
        d2_data_in_valid = 1'b1;
        tick();
        d2_data_in_valid = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick();
            check_eq("sep80_55_sig", d2_signal_out, exp_aa55[i]);
        end

        // Reset mid-byte drops the remaining symbols.
        tick();
        d2_data_in       = 8'h8D;
        d2_data_in_valid = 1'b1;
        tick();
        d2_data_in_valid = 1'b0;
        tick();
        check_eq("mid_sig0", d2_signal_out, 120);
        tick();
        check_eq("mid_sig1", d2_signal_out, -60);
        d2_rstn = 1'b0;
        #1;
        check_eq("mid_rst_sig", d2_signal_out, 0);
        check_eq("mid_rst_valid", d2_signal_out_valid, 0);
        check_eq("mid_rst_busy", d2_busy, 0);
        check_eq("mid_rst_ready", d2_data_in_ready, 0);
        tick();
        d2_rstn = 1'b1;
        #1;
        check_eq("mid_rel_ready", d2_data_in_ready, 1);
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d2_signal_out_valid) n_valid++;
        end
        check_eq("mid_no_resume", n_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
